lcd_bus_decoder: RTL

- Receiving end of the HD44780-style character LCD bus driven by LCD_Display (LCD_EN, LCD_RS, LCD_RW, LCD_DATA).
- Decodes falling-edge EN strobes into commands and character writes.
- Keeps a 2x16 shadow character buffer with a registered random-read port.
- Sits beside LCD_Display on the board top, or in the bench as a checker, so LCD output can be verified and mirrored to HEX digits without the physical panel.

---
 rtl/lcd_bus_decoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_decoder.sv
`default_nettype none
// ============================================================================
// lcd_bus_decoder: HD44780-style LCD bus receiver with a 2x16 shadow buffer.
// Optional LCD_DEC_STATS_EN adds saturating char/command counters.
// Revision: 1.0
// ============================================================================
module lcd_bus_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_EN_HIGH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       char_valid,
    output logic [7:0] char_out,
    output logic [4:0] char_index,
    output logic       cmd_valid,
    output logic [7:0] cmd_out,
    output logic [4:0] cursor,
    output logic       display_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       overrun,
`ifdef LCD_DEC_STATS_EN
    output logic [15:0] char_count,
    output logic [15:0] cmd_count,
`endif
    output logic       rw_error
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] C_SPACE    = 8'h20;
    localparam logic [3:0] C_MIN_HIGH = 4'(MIN_EN_HIGH);

    logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
    logic                   en_prev_q, en_prev_d;
    logic [3:0]             high_cnt_q, high_cnt_d;
    logic                   cap_rs_q, cap_rs_d;
    logic                   cap_rw_q, cap_rw_d;
    logic [7:0]             cap_data_q, cap_data_d;
    state_t                 state_q, state_d;
    logic [4:0]             clr_cnt_q, clr_cnt_d;
    logic [4:0]             cursor_q, cursor_d;
    logic                   display_on_q, display_on_d;
    logic                   entry_inc_q, entry_inc_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   rw_error_q, rw_error_d;
    logic                   char_valid_q, char_valid_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             char_out_q, char_out_d;
    logic [4:0]             char_index_q, char_index_d;
    logic [7:0]             cmd_out_q, cmd_out_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic [7:0]             buf_q [32];

    logic                   en_s;
    logic                   strobe;
    logic [4:0]             addr_idx;
    logic                   buf_we;
    logic [4:0]             buf_waddr;
    logic [7:0]             buf_wdata;

    always_comb begin
        en_s       = en_sync_q[SYNC_STAGES-1];
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], lcd_en};
        en_prev_d  = en_s;
        strobe     = en_prev_q & ~en_s & (high_cnt_q >= C_MIN_HIGH);
        high_cnt_d = !en_s ? 4'd0 : ((high_cnt_q == 4'hF) ? 4'hF : high_cnt_q + 4'd1);

        cap_rs_d   = en_s ? lcd_rs   : cap_rs_q;
        cap_rw_d   = en_s ? lcd_rw   : cap_rw_q;
        cap_data_d = en_s ? lcd_data : cap_data_q;

        // DDRAM line 1 starts at 0x00, line 2 at 0x40; anything else folds.
        if (cap_data_q[6:4] == 3'b000)
            addr_idx = {1'b0, cap_data_q[3:0]};
        else if (cap_data_q[6:4] == 3'b100)
            addr_idx = {1'b1, cap_data_q[3:0]};
        else
            addr_idx = cap_data_q[4:0];

        rd_data_d    = buf_q[rd_addr];
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cursor_d     = cursor_q;
        display_on_d = display_on_q;
        entry_inc_d  = entry_inc_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        rw_error_d   = rw_error_q;
        char_valid_d = 1'b0;
        cmd_valid_d  = 1'b0;
        char_out_d   = char_out_q;
        char_index_d = char_index_q;
        cmd_out_d    = cmd_out_q;
        buf_we       = 1'b0;
        buf_waddr    = cursor_q;
        buf_wdata    = cap_data_q;

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (cap_rw_q) begin
                        rw_error_d = 1'b1;
                    end else if (cap_rs_q) begin
                        buf_we       = 1'b1;
                        char_valid_d = 1'b1;
                        char_out_d   = cap_data_q;
                        char_index_d = cursor_q;
                        cursor_d     = entry_inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_out_d   = cap_data_q;
                        casez (cap_data_q)
                            8'b1???????: cursor_d     = addr_idx;
                            8'b00001???: display_on_d = cap_data_q[2];
                            8'b000001??: entry_inc_d  = cap_data_q[1];
                            8'b0000001?: cursor_d     = 5'd0;
                            8'b00000001: begin
                                cursor_d  = 5'd0;
                                busy_d    = 1'b1;
                                clr_cnt_d = 5'd0;
                                state_d   = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = clr_cnt_q;
                buf_wdata = C_SPACE;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (strobe)
                    overrun_d = 1'b1;
                if (clr_cnt_q == 5'd31) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_sync_q    <= '0;
            en_prev_q    <= 1'b0;
            high_cnt_q   <= 4'd0;
            cap_rs_q     <= 1'b0;
            cap_rw_q     <= 1'b0;
            cap_data_q   <= 8'd0;
            state_q      <= ST_IDLE;
            clr_cnt_q    <= 5'd0;
            cursor_q     <= 5'd0;
            display_on_q <= 1'b0;
            entry_inc_q  <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            rw_error_q   <= 1'b0;
            char_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            char_out_q   <= 8'd0;
            char_index_q <= 5'd0;
            cmd_out_q    <= 8'd0;
            rd_data_q    <= 8'd0;
            for (int i = 0; i < 32; i++)
                buf_q[i] <= C_SPACE;
        end else begin
            en_sync_q    <= en_sync_d;
            en_prev_q    <= en_prev_d;
            high_cnt_q   <= high_cnt_d;
            cap_rs_q     <= cap_rs_d;
            cap_rw_q     <= cap_rw_d;
            cap_data_q   <= cap_data_d;
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cursor_q     <= cursor_d;
            display_on_q <= display_on_d;
            entry_inc_q  <= entry_inc_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            rw_error_q   <= rw_error_d;
            char_valid_q <= char_valid_d;
            cmd_valid_q  <= cmd_valid_d;
            char_out_q   <= char_out_d;
            char_index_q <= char_index_d;
            cmd_out_q    <= cmd_out_d;
            rd_data_q    <= rd_data_d;
            if (buf_we)
                buf_q[buf_waddr] <= buf_wdata;
        end
    end

`ifdef LCD_DEC_STATS_EN
    logic [15:0] char_count_q, char_count_d;
    logic [15:0] cmd_count_q, cmd_count_d;

    always_comb begin
        char_count_d = char_count_q;
        cmd_count_d  = cmd_count_q;
        if (char_valid_d && char_count_q != 16'hFFFF)
            char_count_d = char_count_q + 16'd1;
        if (cmd_valid_d && cmd_count_q != 16'hFFFF)
            cmd_count_d = cmd_count_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            char_count_q <= 16'd0;
            cmd_count_q  <= 16'd0;
        end else begin
            char_count_q <= char_count_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

    assign char_count = char_count_q;
    assign cmd_count  = cmd_count_q;
`endif

    assign rd_data    = rd_data_q;
    assign char_valid = char_valid_q;
    assign char_out   = char_out_q;
    assign char_index = char_index_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_out    = cmd_out_q;
    assign cursor     = cursor_q;
    assign display_on = display_on_q;
    assign entry_inc  = entry_inc_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign rw_error   = rw_error_q;

endmodule
`default_nettype wire
